// File: rtl/ps2_keycode_decoder.sv
// PS/2 scan-code-set-2 receiver and held-key bitmap for two players.
// Player one uses A/D/W/S, player two the E0-prefixed arrow keys.
module ps2_keycode_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       ResetN,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  input  logic       Clear,
  output logic [7:0] Keycode,
  output logic       KeyEvent,
  output logic       FrameErr
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    NORMAL,
    EXT,
    BRK,
    EXTBRK
  } state_t;

  state_t      state;
  logic [1:0]  clk_sync;
  logic [1:0]  dat_sync;
  logic        clk_prev;
  logic        fall;
  logic        din;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        par_bit;
  logic [15:0] to_cnt;
  logic        byte_done;
  logic        byte_good;
  logic        byte_bad;
  logic        timeout_hit;
  logic        is_prefix;
  logic [7:0]  std_mask;
  logic [7:0]  ext_mask;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], PS2Clk};
      dat_sync <= {dat_sync[0], PS2Data};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall        = clk_prev & ~clk_sync[1];
  assign din         = dat_sync[1];
  assign byte_done   = fall && (bit_cnt == 4'd10);
  assign byte_good   = byte_done && din && (^{shreg, par_bit});
  assign byte_bad    = byte_done && !byte_good;
  // A falling edge restarts the idle timer, so it wins over a same-cycle expiry.
  assign timeout_hit = !fall && (bit_cnt != 4'd0) && (to_cnt == TO_LAST);

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      to_cnt   <= '0;
      FrameErr <= 1'b0;
    end else begin
      FrameErr <= byte_bad | timeout_hit;
      if (fall) begin
        to_cnt <= '0;
        case (bit_cnt)
          4'd0: begin
            if (!din) bit_cnt <= 4'd1;
          end
          4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
            shreg   <= {din, shreg[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
          4'd9: begin
            par_bit <= din;
            bit_cnt <= 4'd10;
          end
          default: bit_cnt <= '0;
        endcase
      end else if (bit_cnt != 4'd0) begin
        if (timeout_hit) begin
          bit_cnt <= '0;
          to_cnt  <= '0;
        end else begin
          to_cnt <= to_cnt + 16'd1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  always_comb begin
    std_mask  = '0;
    ext_mask  = '0;
    is_prefix = (shreg == 8'hE0) || (shreg == 8'hF0);
    case (shreg)
      8'h1C:   std_mask = 8'h80;
      8'h23:   std_mask = 8'h40;
      8'h1D:   std_mask = 8'h20;
      8'h1B:   std_mask = 8'h10;
      default: std_mask = '0;
    endcase
    case (shreg)
      8'h6B:   ext_mask = 8'h08;
      8'h74:   ext_mask = 8'h04;
      8'h75:   ext_mask = 8'h02;
      8'h72:   ext_mask = 8'h01;
      default: ext_mask = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state    <= NORMAL;
      Keycode  <= '0;
      KeyEvent <= 1'b0;
    end else begin
      KeyEvent <= 1'b0;
      if (Clear) begin
        Keycode <= '0;
        state   <= NORMAL;
      end else if (byte_bad || timeout_hit) begin
        state <= NORMAL;
      end else if (byte_good) begin
        case (state)
          NORMAL: begin
            if (shreg == 8'hE0) begin
              state <= EXT;
            end else if (shreg == 8'hF0) begin
              state <= BRK;
            end else if (std_mask != '0) begin
              Keycode  <= Keycode | std_mask;
              KeyEvent <= 1'b1;
            end
          end
          EXT: begin
            if (shreg == 8'hF0) begin
              state <= EXTBRK;
            end else if (shreg == 8'hE0) begin
              state <= EXT;
            end else begin
              state <= NORMAL;
              if (ext_mask != '0) begin
                Keycode  <= Keycode | ext_mask;
                KeyEvent <= 1'b1;
              end
            end
          end
          BRK: begin
            state <= NORMAL;
            if (!is_prefix && std_mask != '0) begin
              Keycode  <= Keycode & ~std_mask;
              KeyEvent <= 1'b1;
            end
          end
          default: begin
            state <= NORMAL;
            if (!is_prefix && ext_mask != '0) begin
              Keycode  <= Keycode & ~ext_mask;
              KeyEvent <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
